// File: rtl/total_zero_enc_dc_chroma.sv
// Chroma DC total_zeros encoder: looks up the codeword for one
// (TotalCoeff, TotalZeroes) symbol and shifts it out MSB first over a
// valid/ready bit interface, then reports completion and legality.
module total_zero_enc_dc_chroma (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       InValid,
  output logic       InReady,
  input  logic [3:0] TotalCoeff,
  input  logic [3:0] TotalZeroes,
  output logic       BitOut,
  output logic       BitValid,
  input  logic       BitReady,
  output logic       BitLast,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_shift;
  logic [1:0]  r_cnt;
  logic        r_err;

  logic [2:0]  w_code;
  logic [1:0]  w_len;
  logic        w_err;
  logic        w_accept;

  assign w_accept = InValid && (r_state == IDLE);

  // Codeword lookup; codes are left-aligned in 3 bits, zero-padded below.
  always_comb begin
    w_code = 3'b000;
    w_len  = 2'd0;
    w_err  = 1'b0;
    case (TotalCoeff)
      4'd1: begin
        case (TotalZeroes)
          4'd0:    begin w_code = 3'b100; w_len = 2'd1; end
          4'd1:    begin w_code = 3'b010; w_len = 2'd2; end
          4'd2:    begin w_code = 3'b001; w_len = 2'd3; end
          4'd3:    begin w_code = 3'b000; w_len = 2'd3; end
          default: w_err = 1'b1;
        endcase
      end
      4'd2: begin
        case (TotalZeroes)
          4'd0:    begin w_code = 3'b100; w_len = 2'd1; end
          4'd1:    begin w_code = 3'b010; w_len = 2'd2; end
          4'd2:    begin w_code = 3'b000; w_len = 2'd2; end
          default: w_err = 1'b1;
        endcase
      end
      4'd3: begin
        case (TotalZeroes)
          4'd0:    begin w_code = 3'b100; w_len = 2'd1; end
          4'd1:    begin w_code = 3'b000; w_len = 2'd1; end
          default: w_err = 1'b1;
        endcase
      end
      // With 0 or 4 coefficients total_zeros is implied and not coded.
      4'd0, 4'd4: w_err = (TotalZeroes != 4'd0);
      default:    w_err = 1'b1;
    endcase
  end

  // State register; reset wins over everything, dropping any symbol in flight.
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    w_next   = r_state;
    InReady  = 1'b0;
    BitValid = 1'b0;
    BitOut   = 1'b0;
    BitLast  = 1'b0;
    Done     = 1'b0;
    Err      = 1'b0;
    case (r_state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) w_next = (w_len != 2'd0) ? SHIFT : FIN;
      end
      SHIFT: begin
        BitValid = 1'b1;
        BitOut   = r_shift[2];
        BitLast  = (r_cnt == 2'd1);
        if (BitReady && (r_cnt == 2'd1)) w_next = FIN;
      end
      FIN: begin
        Done   = 1'b1;
        Err    = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Codeword shift register, remaining-bit count and latched error flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_shift <= 3'b000;
      r_cnt   <= 2'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_shift <= w_code;
      r_cnt   <= w_len;
      r_err   <= w_err;
    end else if ((r_state == SHIFT) && BitReady) begin
      r_shift <= {r_shift[1:0], 1'b0};
      r_cnt   <= r_cnt - 2'd1;
    end
  end

endmodule

// File: doc/total_zero_enc_dc_chroma.md
TOTAL_ZERO_ENC_DC_CHROMA -- requirements
Module: total_zero_enc_dc_chroma

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  synchronous active-high reset.
REQ-005 InValid  input  1  symbol request valid.
REQ-006 InReady  output  1  block can accept a symbol.
REQ-007 TotalCoeff  input  4  chroma DC coefficient count, 0..4.
REQ-008 TotalZeroes  input  4  chroma DC total_zeros value to encode.
REQ-009 BitOut  output  1  current codeword bit, MSB first.
REQ-010 BitValid  output  1  BitOut valid.
REQ-011 BitReady  input  1  downstream accepts BitOut.
REQ-012 BitLast  output  1  BitOut is the final bit of the codeword.
REQ-013 Done  output  1  one-cycle pulse: symbol fully processed.
REQ-014 Err  output  1  qualified by Done: TotalCoeff/TotalZeroes combination illegal.

Function
REQ-015 States SHALL be IDLE, SHIFT and FIN.
REQ-016 InReady SHALL be 1 only in IDLE.
REQ-017 A symbol SHALL be accepted on a rising edge with InValid=1 and InReady=1; inputs are sampled only then.
REQ-018 Code/length on acceptance, TotalCoeff=1: TZ0="1"/1, TZ1="01"/2, TZ2="001"/3, TZ3="000"/3.
REQ-019 TotalCoeff=2: TZ0="1"/1, TZ1="01"/2, TZ2="00"/2.
REQ-020 TotalCoeff=3: TZ0="1"/1, TZ1="0"/1.
REQ-021 TotalCoeff=0 or 4 with TotalZeroes=0 SHALL give length 0 (total_zeros not coded) and Err=0.
REQ-022 Every other combination (TotalCoeff>4, or TotalZeroes>4-TotalCoeff) SHALL give length 0 and Err=1.
REQ-023 On acceptance, the codeword SHALL load into a 3-bit left-aligned shift register; a 2-bit remaining-count SHALL load with the length.
REQ-024 IDLE->SHIFT on acceptance when length>0; IDLE->FIN on acceptance when length=0.
REQ-025 In SHIFT: BitValid=1; BitOut=shift-register MSB; BitLast=1 when remaining-count=1.
REQ-026 In SHIFT, with BitReady=1: shift left one, decrement count; if count was 1, go to FIN.
REQ-027 With BitReady=0, BitOut, BitLast and the state SHALL hold unchanged (no bit lost or duplicated).
REQ-028 In FIN: Done=1 and Err=latched error flag for exactly one cycle, then unconditionally to IDLE.
REQ-029 Outside FIN, Done=0 and Err=0; outside SHIFT, BitValid=0 and BitLast=0.
REQ-030 InValid asserted while not in IDLE SHALL be ignored and have no effect.
REQ-031 Minimum spacing between accepted symbols SHALL be length+2 cycles (1 bit: 3 cycles; 0 bits: 2 cycles).
REQ-032 All outputs SHALL be driven from registers or state decode only, with no combinational path from any input.

Reset
REQ-033 Rst=1 at a rising edge SHALL force IDLE, clear the shift register, count and error flag; this includes mid-SHIFT and FIN.
REQ-034 While Rst=1 and on the following cycle: InReady=1, BitValid=0, BitLast=0, Done=0, Err=0, BitOut=0.
REQ-035 A symbol in flight at reset SHALL be dropped with no Done pulse.

Verification
REQ-036 TotalCoeff=1, TotalZeroes=2, BitReady=1 -> bits 0,0,1 on consecutive cycles; BitLast on the third; Done=1, Err=0 the next cycle; InReady=1 one cycle later.
REQ-037 TotalCoeff=2, TotalZeroes=1, BitReady low for 2 cycles on the first bit -> BitOut=0 held 3 cycles, then 1 with BitLast; Done follows.
REQ-038 TotalCoeff=4, TotalZeroes=0 -> no BitValid; Done=1, Err=0 one cycle after acceptance.
REQ-039 TotalCoeff=3, TotalZeroes=2 -> no BitValid; Done=1, Err=1 one cycle after acceptance.
REQ-040 Full table sweep TotalCoeff 0..5 x TotalZeroes 0..4, back-to-back InValid -> serialized bits match REQ-018..REQ-022; InReady=0 while busy.
REQ-041 Rst asserted after the first bit of TotalCoeff=1, TotalZeroes=3 -> BitValid=0 next cycle, no Done, InReady=1; the next symbol encodes correctly.
